// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================
// dmem_pkg - shared types for the data-memory arbiter
// Revision: 1.0
// ============================================================
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RMW_RD = 2'd2,
    RMW_WR = 2'd3
  } state_t;

  typedef logic req_id_t;

endpackage
`default_nettype wire

// File: rtl/dmem_lane_unit.sv
`default_nettype none
// ============================================================
// dmem_lane_unit - sub-word store merge and load extraction
// Revision: 1.0
// ============================================================
module dmem_lane_unit
  import dmem_pkg::*;
(
  input  logic [31:0] i_old_word,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rd_word,
  input  logic [1:0]  i_size,
  input  logic        i_sext,
  output logic [31:0] o_merged,
  output logic [31:0] o_loaded
);

  always_comb begin
    o_merged = i_wdata;
    case (i_size)
      SZ_BYTE:       o_merged = {i_old_word[31:8], i_wdata[7:0]};
      SZ_HALF:       o_merged = {i_old_word[31:16], i_wdata[15:0]};
      SZ_WORD, 2'b11: o_merged = i_wdata;
      default:       o_merged = i_wdata;
    endcase
  end

  always_comb begin
    o_loaded = i_rd_word;
    case (i_size)
      SZ_BYTE:       o_loaded = {{24{i_sext & i_rd_word[7]}}, i_rd_word[7:0]};
      SZ_HALF:       o_loaded = {{16{i_sext & i_rd_word[15]}}, i_rd_word[15:0]};
      SZ_WORD, 2'b11: o_loaded = i_rd_word;
      default:       o_loaded = i_rd_word;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================
// dmem_arbiter - round-robin two-requester data-memory controller
// Revision: 1.0
// ============================================================
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [1:0]        m0_size,
  input  logic              m0_sext,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_done,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [1:0]        m1_size,
  input  logic              m1_sext,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_done,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_read,
  output logic              mem_write_enable,
  input  logic [DATA_W-1:0] mem_read_data
);

  state_t              r_state;
  req_id_t             r_last;
  req_id_t             r_id;
  logic                r_we;
  logic                r_sext;
  logic [1:0]          r_size;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_merge;
  logic                r_mem_read;
  logic                r_mem_we;
  logic [1:0]          r_done;
  logic [DATA_W-1:0]   r_rdata0;
  logic [DATA_W-1:0]   r_rdata1;

  req_id_t             w_win;
  logic                w_gnt;
  logic                w_sel_we;
  logic [1:0]          w_sel_size;
  logic                w_sel_sext;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_wdata;
  logic                w_sub;
  logic [DATA_W-1:0]   w_merged;
  logic [DATA_W-1:0]   w_loaded;

  // On a tie the requester that was not granted last wins.
  assign w_win = (m0_req && m1_req) ? ~r_last : m1_req;
  assign w_gnt = (r_state == IDLE) && (m0_req || m1_req) && !rst;

  always_comb begin
    w_sel_we    = m0_we;
    w_sel_size  = m0_size;
    w_sel_sext  = m0_sext;
    w_sel_addr  = m0_addr;
    w_sel_wdata = m0_wdata;
    if (w_win) begin
      w_sel_we    = m1_we;
      w_sel_size  = m1_size;
      w_sel_sext  = m1_sext;
      w_sel_addr  = m1_addr;
      w_sel_wdata = m1_wdata;
    end
  end

  assign w_sub = w_sel_we && ((w_sel_size == SZ_BYTE) || (w_sel_size == SZ_HALF));

  dmem_lane_unit u_lane (
    .i_old_word (r_merge),
    .i_wdata    (r_wdata),
    .i_rd_word  (mem_read_data),
    .i_size     (r_size),
    .i_sext     (r_sext),
    .o_merged   (w_merged),
    .o_loaded   (w_loaded)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_last     <= 1'b1;
      r_id       <= 1'b0;
      r_we       <= 1'b0;
      r_sext     <= 1'b0;
      r_size     <= SZ_BYTE;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_merge    <= '0;
      r_mem_read <= 1'b0;
      r_mem_we   <= 1'b0;
      r_done     <= 2'b00;
      r_rdata0   <= '0;
      r_rdata1   <= '0;
    end else begin
      r_done     <= 2'b00;
      r_mem_read <= 1'b0;
      r_mem_we   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_gnt) begin
            r_last  <= w_win;
            r_id    <= w_win;
            r_we    <= w_sel_we;
            r_size  <= w_sel_size;
            r_sext  <= w_sel_sext;
            r_addr  <= w_sel_addr;
            r_wdata <= w_sel_wdata;
            if (w_sub) begin
              r_state    <= RMW_RD;
              r_mem_read <= 1'b1;
            end else begin
              r_state    <= ACCESS;
              r_mem_read <= !w_sel_we;
              r_mem_we   <= w_sel_we;
            end
          end
        end
        ACCESS: begin
          r_state      <= IDLE;
          r_done[r_id] <= 1'b1;
          if (!r_we) begin
            if (r_id) r_rdata1 <= w_loaded;
            else      r_rdata0 <= w_loaded;
          end
        end
        RMW_RD: begin
          r_state  <= RMW_WR;
          r_merge  <= mem_read_data;
          r_mem_we <= 1'b1;
        end
        RMW_WR: begin
          r_state      <= IDLE;
          r_done[r_id] <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign m0_gnt           = w_gnt && !w_win;
  assign m1_gnt           = w_gnt && w_win;
  assign m0_done          = r_done[0];
  assign m1_done          = r_done[1];
  assign m0_rdata         = r_rdata0;
  assign m1_rdata         = r_rdata1;
  assign mem_address      = r_addr;
  assign mem_write_data   = (r_state == RMW_WR) ? w_merged : r_wdata;
  // Strobes are masked by rst so a reset cycle can never touch memory.
  assign mem_read         = r_mem_read && !rst;
  assign mem_write_enable = r_mem_we && !rst;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================
// tb_dmem_arbiter - randomized bench with transaction-level model
// Revision: 1.0
// ============================================================
module tb_dmem_arbiter;
  import dmem_pkg::*;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          gap;
  } txn_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        m0_req, m0_we, m0_sext, m0_gnt, m0_done;
  logic        m1_req, m1_we, m1_sext, m1_gnt, m1_done;
  logic [1:0]  m0_size, m1_size;
  logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
  logic [31:0] mem_address, mem_write_data, mem_read_data;
  logic        mem_read, mem_write_enable;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_size(m0_size), .m0_sext(m0_sext),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_done(m0_done),
    .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_size(m1_size), .m1_sext(m1_sext),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_done(m1_done),
    .m1_rdata(m1_rdata),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read(mem_read), .mem_write_enable(mem_write_enable),
    .mem_read_data(mem_read_data)
  );

  // Byte memory seen by the DUT (wraps at 256 bytes) and the model's copy.
  logic [7:0] mem     [256];
  logic [7:0] ref_mem [256];

  always_comb mem_read_data = {mem[8'(mem_address + 32'd3)], mem[8'(mem_address + 32'd2)],
                               mem[8'(mem_address + 32'd1)], mem[8'(mem_address)]};

  always @(posedge clk)
    if (mem_write_enable)
      for (int i = 0; i < 4; i++) mem[8'(mem_address + 32'(i))] <= mem_write_data[8*i +: 8];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  txn_t q0[$];
  txn_t q1[$];
  int   wait0, wait1;

  int          m_last, m_free, e_rd, e_we, e_done, e_id;
  logic        e_load;
  logic [31:0] e_addr, e_wword, e_rval;
  logic [31:0] last_r [2];
  logic        last_ok [2];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    return {ref_mem[8'(a + 32'd3)], ref_mem[8'(a + 32'd2)], ref_mem[8'(a + 32'd1)], ref_mem[8'(a)]};
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {mem[8'(a + 32'd3)], mem[8'(a + 32'd2)], mem[8'(a + 32'd1)], mem[8'(a)]};
  endfunction

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
  endfunction

  task automatic model_reset();
    m_last = 1; m_free = 0; e_rd = -1; e_we = -1; e_done = -1; e_id = 0;
    for (int i = 0; i < 2; i++) begin last_r[i] = 32'd0; last_ok[i] = 1'b1; end
  endtask

  task automatic push(input int id, input logic we, input logic [1:0] sz, input logic sx,
                      input logic [31:0] a, input logic [31:0] d, input int gap);
    txn_t t;
    t.we = we; t.size = sz; t.sext = sx; t.addr = a; t.wdata = d; t.gap = gap;
    if (id == 0) q0.push_back(t); else q1.push_back(t);
  endtask

  task automatic rand_push(input int id, input int maxgap);
    logic [31:0] a;
    a = ($urandom_range(0, 2) == 0) ? 32'h10 + 32'($urandom_range(0, 3)) : $urandom();
    push(id, 1'($urandom), 2'($urandom), 1'($urandom), a, $urandom(), $urandom_range(0, maxgap));
  endtask

  task automatic drive_inputs();
    m0_req = (q0.size() != 0) && (wait0 == 0);
    m1_req = (q1.size() != 0) && (wait1 == 0);
    if (q0.size() != 0) begin
      m0_we = q0[0].we; m0_size = q0[0].size; m0_sext = q0[0].sext;
      m0_addr = q0[0].addr; m0_wdata = q0[0].wdata;
    end
    if (q1.size() != 0) begin
      m1_we = q1[0].we; m1_size = q1[0].size; m1_sext = q1[0].sext;
      m1_addr = q1[0].addr; m1_wdata = q1[0].wdata;
    end
    if (q0.size() != 0 && wait0 > 0) wait0--;
    if (q1.size() != 0 && wait1 > 0) wait1--;
  endtask

  // Model: one transaction at a time, 2 cycles (3 for sub-word stores),
  // effects applied in grant order.
  task automatic sample_cycle();
    int          c;
    int          win;
    int          n;
    int          dur;
    logic [1:0]  eg;
    logic [1:0]  ed;
    logic [31:0] w;
    logic [31:0] mask;
    txn_t        t;
    c = cyc;
    check_eq("strobe", {30'd0, mem_write_enable, mem_read}, {30'd0, (c == e_we), (c == e_rd)});
    if (c == e_rd || c == e_we) check_eq("addr", mem_address, e_addr);
    if (c == e_we) check_eq("wdata", mem_write_data, e_wword);
    ed = (c == e_done) ? ((e_id == 1) ? 2'b10 : 2'b01) : 2'b00;
    check_eq("done", {30'd0, m1_done, m0_done}, {30'd0, ed});
    if (c == e_done) begin
      last_ok[e_id] = e_load;
      last_r[e_id]  = e_rval;
    end
    for (int i = 0; i < 2; i++)
      if (last_ok[i]) check_eq((i == 0) ? "rdata0" : "rdata1", (i == 0) ? m0_rdata : m1_rdata, last_r[i]);

    eg  = 2'b00;
    win = 0;
    if (c >= m_free && (m0_req || m1_req)) begin
      win = (m0_req && m1_req) ? 1 - m_last : (m1_req ? 1 : 0);
      eg  = (win == 1) ? 2'b10 : 2'b01;
    end
    check_eq("gnt", {30'd0, m1_gnt, m0_gnt}, {30'd0, eg});
    if (eg != 2'b00) begin
      if (win == 1) t = q1.pop_front(); else t = q0.pop_front();
      if (win == 1) wait1 = (q1.size() != 0) ? q1[0].gap : 0;
      else          wait0 = (q0.size() != 0) ? q0[0].gap : 0;
      m_last = win;
      n      = nbytes(t.size);
      dur    = (t.we && n < 4) ? 3 : 2;
      m_free = c + dur;
      e_done = c + dur;
      e_id   = win;
      e_load = !t.we;
      e_addr = t.addr;
      e_rd   = (!t.we || n < 4) ? c + 1 : -1;
      e_we   = t.we ? c + dur - 1 : -1;
      w      = ref_word(t.addr);
      if (!t.we) begin
        if (n < 4) begin
          mask = (32'd1 << (8 * n)) - 32'd1;
          w    = w & mask;
          if (t.sext && w[8*n-1]) w = w | ~mask;
        end
        e_rval = w;
      end else begin
        for (int i = 0; i < n; i++) begin
          w[8*i +: 8] = t.wdata[8*i +: 8];
          ref_mem[8'(t.addr + 32'(i))] = t.wdata[8*i +: 8];
        end
        e_wword = w;
      end
    end
  endtask

  task automatic run_engine(input int budget);
    int n;
    bit go;
    n  = 0;
    go = 1'b1;
    wait0 = (q0.size() != 0) ? q0[0].gap : 0;
    wait1 = (q1.size() != 0) ? q1[0].gap : 0;
    drive_inputs();
    while (go) begin
      @(negedge clk);
      sample_cycle();
      n++;
      go = (q0.size() != 0) || (q1.size() != 0) || (cyc < m_free);
      if (go && n >= budget) begin
        check_eq("engine_timeout", 32'(n), 32'(budget + 1));
        go = 1'b0;
        q0.delete();
        q1.delete();
      end
      @(posedge clk); #1;
      drive_inputs();
    end
  endtask

  task automatic do_reset(input int ncyc);
    @(posedge clk); #1;
    rst = 1'b1; m0_req = 1'b0; m1_req = 1'b0;
    for (int j = 0; j < ncyc; j++) begin
      @(negedge clk);
      check_eq("rst_ctl", {26'd0, mem_write_enable, mem_read, m1_done, m0_done, m1_gnt, m0_gnt}, 32'd0);
      if (j > 0) begin
        check_eq("rst_rdata0", m0_rdata, 32'd0);
        check_eq("rst_rdata1", m1_rdata, 32'd0);
        check_eq("rst_addr", mem_address, 32'd0);
        check_eq("rst_wdata", mem_write_data, 32'd0);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int k;
    rst = 1'b1;
    m0_req = 0; m0_we = 0; m0_size = 0; m0_sext = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_size = 0; m1_sext = 0; m1_addr = 0; m1_wdata = 0;
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    model_reset();
    do_reset(3);

    // Store/read-back, byte and half merges, load extension.
    push(0, 1, SZ_WORD, 0, 32'h10, 32'hDEADBEEF, 0);
    push(0, 0, SZ_WORD, 0, 32'h10, 32'h0, 0);
    push(0, 1, SZ_BYTE, 0, 32'h11, 32'h555555AB, 0);
    push(0, 0, SZ_WORD, 0, 32'h10, 32'h0, 0);
    push(0, 1, SZ_HALF, 0, 32'h12, 32'h99991234, 0);
    push(0, 0, SZ_WORD, 0, 32'h10, 32'h0, 0);
    push(0, 0, SZ_BYTE, 1, 32'h11, 32'h0, 0);
    push(0, 0, SZ_BYTE, 0, 32'h11, 32'h0, 0);
    run_engine(200);
    check_eq("plan_word", mem_word(32'h10), 32'h1234ABEF);
    check_eq("plan_zext", m0_rdata, 32'h000000AB);

    // Contention from reset: both requesters always pending.
    do_reset(2);
    for (int i = 0; i < 8; i++) begin
      push(0, 1'($urandom), 2'($urandom), 1'($urandom), 32'h10 + 32'($urandom_range(0, 3)), $urandom(), 0);
      push(1, 1'($urandom), 2'($urandom), 1'($urandom), 32'h10 + 32'($urandom_range(0, 3)), $urandom(), 0);
    end
    run_engine(200);

    // Random traffic with idle gaps.
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 25; i++) begin
        rand_push(0, 3);
        rand_push(1, 3);
      end
      run_engine(2000);
    end

    // Reset in the RMW_RD cycle of a byte store.
    m0_req = 1; m0_we = 1; m0_size = SZ_BYTE; m0_sext = 0; m0_addr = 32'h10; m0_wdata = 32'h000000C3;
    k = 0;
    @(negedge clk);
    while (!m0_gnt && k < 20) begin @(negedge clk); k++; end
    check_eq("rmw_gnt", {31'd0, m0_gnt}, 32'd1);
    @(posedge clk); #1;
    m0_req = 0; rst = 1;
    @(negedge clk);
    check_eq("rmw_rst_ctl", {29'd0, mem_write_enable, mem_read, m0_done}, 32'd0);
    @(posedge clk); #1;
    rst = 0;
    model_reset();
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      check_eq("rmw_quiet", {29'd0, mem_write_enable, m1_done, m0_done}, 32'd0);
    end
    check_eq("rmw_mem", mem_word(32'h10), ref_word(32'h10));
    @(posedge clk); #1;

    // After reset the tie must go to m0 first.
    push(0, 0, SZ_WORD, 0, 32'h10, 32'h0, 0);
    push(1, 0, SZ_HALF, 1, 32'h12, 32'h0, 0);
    run_engine(50);

    for (int a = 0; a < 256; a += 4) check_eq("mem_final", mem_word(32'(a)), ref_word(32'(a)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester controller for the byte-addressed data memory. Arbitrates between the CPU load/store port (requester 0) and the loader/debug port (requester 1), sequences each access onto the memory's single read/write port, and performs read-modify-write for byte and halfword stores, because the memory always writes four bytes. Sits between the pipeline MEM stage / loader and the data memory.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width; fixed at 32 in this design

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `m0_req`, `m1_req`  in  1  request; held until granted
- `m0_we`, `m1_we`  in  1  1 = store, 0 = load
- `m0_size`, `m1_size`  in  2  00 byte, 01 half, 10 word, 11 treated as word
- `m0_sext`, `m1_sext`  in  1  loads only: 1 sign-extends, 0 zero-extends
- `m0_addr`, `m1_addr`  in  32  byte address; any alignment
- `m0_wdata`, `m1_wdata`  in  32  store data; the low `size` bytes are used
- `m0_gnt`, `m1_gnt`  out  1  one-cycle pulse; the request is latched in this cycle
- `m0_done`, `m1_done`  out  1  one-cycle pulse; the transaction has completed
- `m0_rdata`, `m1_rdata`  out  32  load result; valid when `done` is high and the transaction was a load
- `mem_address`  out  32  memory byte address
- `mem_write_data`  out  32  memory write word
- `mem_read`  out  1  memory read strobe
- `mem_write_enable`  out  1  memory write enable; memory writes bytes addr..addr+3 on `clk`
- `mem_read_data`  in  32  combinational read word; little-endian, byte at addr in [7:0]

## Operation
FSM states:
- `IDLE`
  - If any `req` is high, choose a winner by round robin, pulse its `gnt`, and latch `we`, `size`, `sext`, `addr`, `wdata` and the requester id.
  - Next state: `ACCESS` for loads and word stores; `RMW_RD` for byte and halfword stores.
- `ACCESS`
  - Load: `mem_read`=1 and `mem_address`=latched addr. Extract `size` bytes from `mem_read_data[7:0]` up, sign- or zero-extend, and register the result.
  - Word store: `mem_write_enable`=1 and `mem_write_data`=latched wdata.
  - Next state: `IDLE`.
- `RMW_RD`
  - `mem_read`=1; register `mem_read_data` into the merge register.
  - Next state: `RMW_WR`.
- `RMW_WR`
  - `mem_write_enable`=1.
  - `mem_write_data` = merge register with [7:0] (byte) or [15:0] (half) replaced by wdata.
  - Next state: `IDLE`.

Arbitration and outputs:
- Round robin: the last-granted pointer resets to 1, so requester 0 wins the first tie. After each grant the other requester has priority.
- A requester that is not granted keeps `req` asserted. No request is lost or reordered.
- `done` and `rdata` are registered. `rdata` holds its value until the next load completes for that requester. The value of `rdata` after a store is undefined.
- `mem_address` holds the latched address in all states. It is 0 after reset.
- `mem_read` and `mem_write_enable` are 0 in `IDLE` and during any `rst` cycle.

Reset:
- Outputs: all `gnt`, `done`, `mem_read` and `mem_write_enable` are 0. `rdata`, `mem_address` and `mem_write_data` are 0.
- State: FSM to `IDLE`.
- Reset mid-transaction drops the transaction with no write and no `done`. A sub-word store interrupted after `RMW_RD` leaves memory unchanged.

## Timing
- Acceptance cycle A (`gnt` high).
  - Load: read in A+1; `done` and `rdata` in A+2.
  - Word store: write at the end of A+1; `done` in A+2.
  - Byte or half store: read in A+1; write at the end of A+2; `done` in A+3.
- The FSM is in `IDLE` in the cycle `done` is high, so a new grant can coincide with `done`. Peak throughput is one load or word store every 2 cycles.
- A load granted immediately after a store to the same address returns the stored data.
- `gnt` never asserts for both requesters in the same cycle.
- Requests presented while the FSM is not in `IDLE` are ignored until it returns to `IDLE`.

## Structure
- Package `dmem_pkg`:
  - size encodings `SZ_BYTE`, `SZ_HALF`, `SZ_WORD`
  - FSM state enum `{IDLE, ACCESS, RMW_RD, RMW_WR}`
  - requester id type
- Sub-module `dmem_lane_unit`, combinational:
  - store merge: old word, wdata, size -> new word
  - load extract: word, size, sext -> result
- The top level holds the FSM, the round-robin pointer, the latch registers and the output registers.

## Test plan
- Word store and read-back: m0 stores 0xDEADBEEF at 0x10 (word). `m0_done` at A+2. A word load from 0x10 then returns 0xDEADBEEF.
- Byte store merge: m0 stores byte 0xAB at 0x11. `mem_write_enable` is high only in A+2 and `done` is at A+3. A word load from 0x10 returns 0xDEADABEF. A following halfword store of 0x1234 at 0x12 makes the word 0x1234ABEF.
- Load extension at 0x11: signed byte load returns 0xFFFFFFAB; unsigned byte load returns 0x000000AB.
- Contention: both requesters hold `req` from reset. Grants go m0, m1, m0, m1, with no overlap. Each `done` goes to the requester that was granted.
- Reset mid-RMW: assert `rst` in the `RMW_RD` cycle of a byte store to 0x10. No `mem_write_enable`, no `done`, memory unchanged. The FSM is in `IDLE` after reset and grants m0 first.
